// File: rtl/inst_dispatch.sv
// inst_dispatch: per-channel instruction FIFOs feeding IDLE/ISSUE/HOLD issue FSMs.
// Optional feature macro: INST_DISPATCH_OVERFLOW_EN enables sticky per-channel drop flags.
module inst_dispatch #(
    parameter int CHANNELS   = 4,
    parameter int INST_WIDTH = 12,
    parameter int DEPTH      = 4
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [INST_WIDTH-1:0]          inst,
    input  logic [CHANNELS-1:0]            inst_en,
    input  logic [CHANNELS-1:0]            ch_ready,
    output logic [CHANNELS*INST_WIDTH-1:0] ch_inst,
    output logic [CHANNELS-1:0]            ch_inst_en,
    output logic [CHANNELS-1:0]            full,
    output logic [CHANNELS-1:0]            empty,
    output logic                           idle,
    output logic [CHANNELS-1:0]            overflow,
    input  logic [CHANNELS-1:0]            overflow_clr
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_t;

    logic [CHANNELS-1:0] ch_idle;

    assign idle = &ch_idle;

`ifndef INST_DISPATCH_OVERFLOW_EN
    logic unused_overflow_clr;
    assign unused_overflow_clr = ^overflow_clr;
`endif

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        logic [INST_WIDTH-1:0] mem [DEPTH];
        logic [PW-1:0]         wr_ptr;
        logic [PW-1:0]         rd_ptr;
        logic [CW-1:0]         count;
        state_t                state;
        logic [INST_WIDTH-1:0] inst_q;
        logic                  strobe_q;
        logic                  pop;
        logic                  push;

        // A pop only leaves IDLE, so a full FIFO can accept a push in the same cycle it issues
        assign pop  = (state == IDLE) && (count != '0) && ch_ready[g];
        assign push = inst_en[g] && ((count != DEPTH_C) || pop);

        assign full[g]  = (count == DEPTH_C);
        assign empty[g] = (count == '0);
        assign ch_idle[g] = (state == IDLE) && (count == '0);
        assign ch_inst[g*INST_WIDTH +: INST_WIDTH] = inst_q;
        assign ch_inst_en[g] = strobe_q;

        // Storage array; contents are don't-care while count says empty, so no reset
        always_ff @(posedge clock) begin
            if (push) begin
                mem[wr_ptr] <= inst;
            end
        end

        // Pointers and occupancy count
        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                case ({push, pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end

        // Issue FSM with registered instruction slice and one-cycle strobe
        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                state    <= IDLE;
                inst_q   <= '0;
                strobe_q <= 1'b0;
            end else begin
                strobe_q <= 1'b0;
                case (state)
                    IDLE: begin
                        if (pop) begin
                            state    <= ISSUE;
                            inst_q   <= mem[rd_ptr];
                            strobe_q <= 1'b1;
                        end
                    end
                    ISSUE:   state <= HOLD;
                    HOLD:    state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end

`ifdef INST_DISPATCH_OVERFLOW_EN
        logic ovf_q;

        // Sticky drop flag; a drop wins over a same-cycle clear
        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                ovf_q <= 1'b0;
            end else if (inst_en[g] && !push) begin
                ovf_q <= 1'b1;
            end else if (overflow_clr[g]) begin
                ovf_q <= 1'b0;
            end
        end

        assign overflow[g] = ovf_q;
`else
        assign overflow[g] = 1'b0;
`endif
    end

endmodule

// File: tb/tb_inst_dispatch.sv
// Scoreboard bench for inst_dispatch: transaction-level channel model feeds expected
// strobes into per-channel queues; a negedge monitor pops and compares.
module tb_inst_dispatch;

    localparam int CH = 4;
    localparam int W  = 12;
    localparam int D  = 4;
`ifdef INST_DISPATCH_OVERFLOW_EN
    localparam bit OVF_ON = 1'b1;
`else
    localparam bit OVF_ON = 1'b0;
`endif

    logic            clock;
    logic            reset;
    logic [W-1:0]    inst;
    logic [CH-1:0]   inst_en;
    logic [CH-1:0]   ch_ready;
    logic [CH*W-1:0] ch_inst;
    logic [CH-1:0]   ch_inst_en;
    logic [CH-1:0]   full;
    logic [CH-1:0]   empty;
    logic            idle;
    logic [CH-1:0]   overflow;
    logic [CH-1:0]   overflow_clr;

    inst_dispatch #(.CHANNELS(CH), .INST_WIDTH(W), .DEPTH(D)) dut (
        .clock(clock), .reset(reset), .inst(inst), .inst_en(inst_en),
        .ch_ready(ch_ready), .ch_inst(ch_inst), .ch_inst_en(ch_inst_en),
        .full(full), .empty(empty), .idle(idle), .overflow(overflow),
        .overflow_clr(overflow_clr)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    // Reference model: pending entries, post-issue busy time, sticky flag
    bit [W-1:0] mq    [CH][$];
    bit [W-1:0] exp_v [CH][$];
    int         exp_t [CH][$];
    int         cool  [CH];
    bit         m_ovf [CH];
    bit [W-1:0] last  [CH];

    task automatic chk(input string nm, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", nm, cyc, act, expv);
        end
    endtask

    function automatic void model_clear();
        for (int c = 0; c < CH; c++) begin
            mq[c].delete();
            exp_v[c].delete();
            exp_t[c].delete();
            cool[c]  = 0;
            m_ovf[c] = 1'b0;
            last[c]  = '0;
        end
    endfunction

    // Apply inputs for the current cycle and advance the model across the next edge
    task automatic drive(input bit [W-1:0] iv, input bit [CH-1:0] en,
                         input bit [CH-1:0] rdy, input bit [CH-1:0] clr);
        inst = iv; inst_en = en; ch_ready = rdy; overflow_clr = clr;
        for (int c = 0; c < CH; c++) begin
            bit drop;
            if (cool[c] > 0) begin
                cool[c]--;
            end else if (mq[c].size() > 0 && rdy[c]) begin
                exp_v[c].push_back(mq[c].pop_front());
                exp_t[c].push_back(cyc + 1);
                cool[c] = 2;
            end
            drop = 1'b0;
            if (en[c]) begin
                if (mq[c].size() < D) mq[c].push_back(iv);
                else drop = 1'b1;
            end
            if (OVF_ON) begin
                if (drop) m_ovf[c] = 1'b1;
                else if (clr[c]) m_ovf[c] = 1'b0;
            end
        end
    endtask

    task automatic step(input bit [W-1:0] iv, input bit [CH-1:0] en,
                        input bit [CH-1:0] rdy, input bit [CH-1:0] clr);
        @(negedge clock);
        #1;
        drive(iv, en, rdy, clr);
    endtask

    // Assert reset now, verify outputs respond without a clock, then hold it
    task automatic reset_now();
        reset = 1'b0; inst_en = '0; overflow_clr = '0;
        model_clear();
        #1;
        chk("rst_ch_inst", int'(ch_inst), 0);
        chk("rst_strobe", int'(ch_inst_en), 0);
        chk("rst_full", int'(full), 0);
        chk("rst_empty", int'(empty), 'hF);
        chk("rst_idle", int'(idle), 1);
        chk("rst_overflow", int'(overflow), 0);
        @(negedge clock);
        @(negedge clock);
        #1;
        reset = 1'b1;
    endtask

    // Monitor: strobes against scoreboard, status flags against model
    always @(negedge clock) begin
        if (reset) begin
            bit [CH-1:0] e_full, e_empty, e_ovf;
            bit          e_idle;
            e_idle = 1'b1;
            for (int c = 0; c < CH; c++) begin
                if (exp_v[c].size() > 0 && exp_t[c][0] < cyc) begin
                    checks++; errors++;
                    $display("FAIL strobe_missing ch%0d at cycle %0d: no strobe observed, expected 0x%0h at cycle %0d",
                             c, cyc, exp_v[c][0], exp_t[c][0]);
                    void'(exp_v[c].pop_front());
                    void'(exp_t[c].pop_front());
                end
                if (ch_inst_en[c]) begin
                    if (exp_v[c].size() == 0) begin
                        checks++; errors++;
                        $display("FAIL strobe_spurious ch%0d at cycle %0d: got 0x%0h expected no strobe",
                                 c, cyc, ch_inst[c*W +: W]);
                    end else begin
                        last[c] = exp_v[c].pop_front();
                        chk($sformatf("strobe_val_ch%0d", c), int'(ch_inst[c*W +: W]), int'(last[c]));
                        chk($sformatf("strobe_cyc_ch%0d", c), cyc, exp_t[c].pop_front());
                    end
                end
                chk($sformatf("slice_hold_ch%0d", c), int'(ch_inst[c*W +: W]), int'(last[c]));
                e_full[c]  = (mq[c].size() == D);
                e_empty[c] = (mq[c].size() == 0);
                e_ovf[c]   = m_ovf[c];
                if (mq[c].size() != 0 || cool[c] != 0) e_idle = 1'b0;
            end
            chk("full", int'(full), int'(e_full));
            chk("empty", int'(empty), int'(e_empty));
            chk("overflow", int'(overflow), int'(e_ovf));
            chk("idle", int'(idle), int'(e_idle));
        end
    end

    initial begin
        reset = 1'b0; inst = '0; inst_en = '0; ch_ready = '0; overflow_clr = '0;
        model_clear();
        reset_now();
        // First edge after release accepts a push; single issue to ch0, then idle
        drive(12'h0A5, 4'b0001, 4'b1111, 4'b0000);
        repeat (6) step(0, 4'b0000, 4'b1111, 4'b0000);

        // ch1 stalled: five pushes, fifth dropped; then release in order
        for (int k = 1; k <= 5; k++) step(12'h100 + 12'(k), 4'b0010, 4'b1101, 4'b0000);
        repeat (3) step(0, 4'b0000, 4'b1101, 4'b0000);
        repeat (16) step(0, 4'b0000, 4'b1111, 4'b0000);

        // ch0 overflow: drop + clear same cycle keeps flag, clear alone drops it
        for (int k = 0; k < 5; k++) step(12'h0C0 + 12'(k), 4'b0001, 4'b1110, 4'b0000);
        step(12'h0CF, 4'b0001, 4'b1110, 4'b0001);
        step(0, 4'b0000, 4'b1110, 4'b0001);
        repeat (16) step(0, 4'b0000, 4'b1111, 4'b0000);

        // Broadcast
        step(12'h7FF, 4'b1111, 4'b1111, 4'b0000);
        repeat (5) step(0, 4'b0000, 4'b1111, 4'b0000);

        // ch2 full, pop and push in the same cycle
        for (int k = 1; k <= 4; k++) step(12'h2A0 + 12'(k), 4'b0100, 4'b1011, 4'b0000);
        step(12'h222, 4'b0100, 4'b1111, 4'b0000);
        repeat (16) step(0, 4'b0000, 4'b1111, 4'b0000);

        // Reset while ch3 is issuing with two entries still queued
        for (int k = 1; k <= 3; k++) step(12'h300 + 12'(k), 4'b1000, 4'b0111, 4'b0000);
        step(0, 4'b0000, 4'b1111, 4'b0000);
        @(posedge clock);
        #1;
        chk("pre_reset_strobe_ch3", int'(ch_inst_en[3]), 1);
        reset_now();
        drive(0, 4'b0000, 4'b1111, 4'b0000);
        repeat (8) step(0, 4'b0000, 4'b1111, 4'b0000);
        step(12'h3EE, 4'b1000, 4'b1111, 4'b0000);
        repeat (5) step(0, 4'b0000, 4'b1111, 4'b0000);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            bit [CH-1:0] en, rdy, clr;
            for (int c = 0; c < CH; c++) begin
                en[c]  = ($urandom_range(0, 3) == 0);
                rdy[c] = ($urandom_range(0, 9) < 7);
                clr[c] = ($urandom_range(0, 9) == 0);
            end
            step(W'($urandom), en, rdy, clr);
        end

        // Drain: every expected strobe must have been observed
        repeat (30) step(0, 4'b0000, 4'b1111, 4'b0000);
        @(negedge clock);
        #1;
        for (int c = 0; c < CH; c++) chk($sformatf("drained_ch%0d", c), exp_v[c].size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
